handshake_pack: RTL and testbench

HANDSHAKE_PACK -- requirements
Module: handshake_pack

---
 rtl/handshake_pack.sv | 108 ++++++++++
 tb/tb_handshake_pack.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_pack.sv
// handshake_pack: packs PACK_COUNT narrow beats into one wide word with
// valid/ready handshakes on both sides. A word closes early on i_last.
// The output register is a single skid-free stage: a completing beat may be
// accepted in the same cycle the previous word leaves, so full throughput is
// one beat per cycle.
module handshake_pack #(
    parameter int unsigned VALUE_BITS = 8,
    parameter int unsigned PACK_COUNT = 4,
    parameter int unsigned COUNT_BITS = $clog2(PACK_COUNT) + 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [VALUE_BITS-1:0]          i_value,
    input  logic                           i_last,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [VALUE_BITS*PACK_COUNT-1:0] o_value,
    output logic [COUNT_BITS-1:0]          o_count,
    output logic                           o_last,
    output logic                           o_valid,
    input  logic                           i_ready
);

    localparam int unsigned WORD_BITS = VALUE_BITS * PACK_COUNT;
    localparam logic [COUNT_BITS-1:0] LAST_LANE = COUNT_BITS'(PACK_COUNT - 1);

    // Partial-word accumulator and its fill pointer (next free lane).
    logic [WORD_BITS-1:0]  acc_q, acc_d;
    logic [COUNT_BITS-1:0] fill_q, fill_d;

    // Output word register.
    logic [WORD_BITS-1:0]  o_value_q, o_value_d;
    logic [COUNT_BITS-1:0] o_count_q, o_count_d;
    logic                  o_last_q, o_last_d;
    logic                  o_valid_q, o_valid_d;

    logic                  accept;
    logic                  complete;
    logic [WORD_BITS-1:0]  merged;

    // Ready only looks at the output register, never at the upstream beat.
    assign o_ready = ~o_valid_q | i_ready;

    assign o_value = o_value_q;
    assign o_count = o_count_q;
    assign o_last  = o_last_q;
    assign o_valid = o_valid_q;

    // Merge the incoming beat into its lane and compute next state.
    always_comb begin
        accept   = i_valid & o_ready;
        merged   = acc_q;
        for (int unsigned i = 0; i < PACK_COUNT; i++) begin
            if (fill_q == COUNT_BITS'(i)) begin
                merged[i*VALUE_BITS +: VALUE_BITS] = i_value;
            end
        end
        complete = accept & (i_last | (fill_q == LAST_LANE));

        acc_d     = acc_q;
        fill_d    = fill_q;
        o_value_d = o_value_q;
        o_count_d = o_count_q;
        o_last_d  = o_last_q;
        o_valid_d = o_valid_q;

        if (o_valid_q && i_ready) begin
            o_valid_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                // Accumulator lanes above fill_q are already zero, so the
                // unused upper lanes of the word read as zero.
                o_value_d = merged;
                o_count_d = fill_q + COUNT_BITS'(1);
                o_last_d  = i_last;
                o_valid_d = 1'b1;
                acc_d     = '0;
                fill_d    = '0;
            end else begin
                acc_d  = merged;
                fill_d = fill_q + COUNT_BITS'(1);
            end
        end
    end

    // State registers with synchronous reset; reset discards partial and
    // pending words, so nothing is captured while reset is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q     <= '0;
            fill_q    <= '0;
            o_value_q <= '0;
            o_count_q <= '0;
            o_last_q  <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            o_value_q <= o_value_d;
            o_count_q <= o_count_d;
            o_last_q  <= o_last_d;
            o_valid_q <= o_valid_d;
        end
    end

endmodule

// File: tb/tb_handshake_pack.sv
// Testbench for handshake_pack (VALUE_BITS=8, PACK_COUNT=4). Inputs change on
// the falling edge; outputs are sampled 1ns later. A reference packer pushes
// expected words on every accepted beat; observed transfers are collected and
// compared in each scenario task.
module tb_handshake_pack;

    localparam int VB = 8;
    localparam int PC = 4;
    localparam int CB = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [VB-1:0] i_value;
    logic          i_last;
    logic          i_valid;
    logic          o_ready;
    logic [VB*PC-1:0] o_value;
    logic [CB-1:0] o_count;
    logic          o_last;
    logic          o_valid;
    logic          i_ready;

    typedef struct {
        logic [VB*PC-1:0] v;
        logic [CB-1:0]    c;
        logic             l;
    } word_t;

    word_t exp_q[$];
    word_t got_q[$];

    logic [VB*PC-1:0] mdl_acc;
    int               mdl_fill;

    int n_cmp = 0;
    int n_bad = 0;

    handshake_pack #(
        .VALUE_BITS(VB),
        .PACK_COUNT(PC),
        .COUNT_BITS(CB)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .i_value(i_value),
        .i_last (i_last),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_value(o_value),
        .o_count(o_count),
        .o_last (o_last),
        .o_valid(o_valid),
        .i_ready(i_ready)
    );

    always #5 clock = ~clock;

    // Reference packer: called for every beat the bench sees accepted.
    task automatic mdl_accept(input logic [VB-1:0] val, input logic lst);
        word_t w;
        mdl_acc[mdl_fill*VB +: VB] = val;
        if (lst || mdl_fill == PC - 1) begin
            w.v = mdl_acc;
            w.c = CB'(mdl_fill + 1);
            w.l = lst;
            exp_q.push_back(w);
            mdl_acc  = '0;
            mdl_fill = 0;
        end else begin
            mdl_fill++;
        end
    endtask

    task automatic mdl_clear();
        mdl_acc  = '0;
        mdl_fill = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    // One clock of stimulus; records transfers and feeds accepted beats to the model.
    task automatic drive_cycle(input logic v, input logic [VB-1:0] val, input logic lst,
                               input logic rdy, output logic acc, output logic ovld,
                               output logic [VB*PC-1:0] ov);
        word_t w;
        @(negedge clock);
        i_valid = v;
        i_value = val;
        i_last  = lst;
        i_ready = rdy;
        #1;
        ovld = o_valid;
        ov   = o_value;
        acc  = v & o_ready & ~reset;
        if (o_valid === 1'b1 && rdy) begin
            w.v = o_value;
            w.c = o_count;
            w.l = o_last;
            got_q.push_back(w);
        end
        if (acc) mdl_accept(val, lst);
    endtask

    // Present one beat until accepted, with a bounded wait.
    task automatic send_beat(input logic [VB-1:0] val, input logic lst);
        logic acc, ovld;
        logic [VB*PC-1:0] ov;
        int tries = 0;
        acc = 1'b0;
        while (!acc && tries < 50) begin
            drive_cycle(1'b1, val, lst, 1'b1, acc, ovld, ov);
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_beat_timeout: beat %02h not accepted, required accept within 50", val);
        end
    endtask

    task automatic drain(input int cycles);
        logic acc, ovld;
        logic [VB*PC-1:0] ov;
        repeat (cycles) drive_cycle(1'b0, '0, 1'b0, 1'b1, acc, ovld, ov);
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset   = 1'b1;
        i_valid = 1'b1;
        i_value = 8'h99;
        i_last  = 1'b1;
        i_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_value !== 32'h0) begin n_bad++; $display("FAIL reset_o_value: got %08h want 00000000", o_value); end
        n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL reset_o_count: got %0d want 0", o_count); end
        n_cmp++; if (o_last !== 1'b0) begin n_bad++; $display("FAIL reset_o_last: got %b want 0", o_last); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
        reset   = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        mdl_clear();
    endtask

    task automatic test_full_word();
        logic acc, ovld;
        logic [VB*PC-1:0] ov;
        word_t g, e;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, acc, ovld, ov);
        n_cmp++; if (ovld !== 1'b1) begin n_bad++; $display("FAIL full_valid_after: got %b want 1", ovld); end
        drive_cycle(1'b0, '0, 1'b0, 1'b1, acc, ovld, ov);
        n_cmp++; if (ovld !== 1'b0) begin n_bad++; $display("FAIL full_valid_one_cycle: got %b want 0", ovld); end
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++;
            $display("FAIL full_word_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g.v !== e.v || g.c !== e.c || g.l !== e.l || g.v !== 32'h44332211) begin
                n_bad++;
                $display("FAIL full_word: got %08h/%0d/%b want %08h/%0d/%b", g.v, g.c, g.l, e.v, e.c, e.l);
            end
        end
    endtask

    task automatic test_single_last();
        word_t g, e;
        send_beat(8'hAA, 1'b1);
        drain(2);
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++;
            $display("FAIL single_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g.v !== e.v || g.c !== e.c || g.l !== e.l || g.v !== 32'h000000AA || g.c !== 3'd1) begin
                n_bad++;
                $display("FAIL single_last: got %08h/%0d/%b want %08h/%0d/%b", g.v, g.c, g.l, e.v, e.c, e.l);
            end
        end
    endtask

    task automatic test_stall();
        logic acc, ovld;
        logic [VB*PC-1:0] ov;
        word_t g, e;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 8'h55, 1'b0, 1'b0, acc, ovld, ov);
            n_cmp++;
            if (o_ready !== 1'b0 || ovld !== 1'b1 || ov !== 32'h44332211) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: ready %b valid %b value %08h want 0 1 44332211",
                         i, o_ready, ovld, ov);
            end
        end
        send_beat(8'h55, 1'b0);
        send_beat(8'h66, 1'b0);
        send_beat(8'h77, 1'b0);
        send_beat(8'h88, 1'b0);
        drain(2);
        n_cmp++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            n_bad++;
            $display("FAIL stall_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g.v !== e.v || g.c !== e.c || g.l !== e.l) begin
                n_bad++;
                $display("FAIL stall_word: got %08h/%0d/%b want %08h/%0d/%b", g.v, g.c, g.l, e.v, e.c, e.l);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc, ovld;
        logic [VB*PC-1:0] ov;
        word_t g, e;
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1, 8'(i), 1'b0, 1'b1, acc, ovld, ov);
            n_cmp++;
            if (acc !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_accept[%0d]: got %b want 1", i, acc);
            end
        end
        drain(2);
        n_cmp++;
        if (got_q.size() != 2 || exp_q.size() != 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g.v !== e.v || g.c !== e.c || g.l !== e.l) begin
                n_bad++;
                $display("FAIL b2b_word: got %08h/%0d/%b want %08h/%0d/%b", g.v, g.c, g.l, e.v, e.c, e.l);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        word_t g, e;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        @(negedge clock);
        reset   = 1'b1;
        i_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        mdl_clear();
        send_beat(8'h0A, 1'b0);
        send_beat(8'h0B, 1'b0);
        send_beat(8'h0C, 1'b0);
        send_beat(8'h0D, 1'b0);
        drain(2);
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++;
            $display("FAIL midreset_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g.v !== e.v || g.c !== e.c || g.l !== e.l || g.v !== 32'h0D0C0B0A || g.c !== 3'd4) begin
                n_bad++;
                $display("FAIL midreset_word: got %08h/%0d/%b want %08h/%0d/%b", g.v, g.c, g.l, e.v, e.c, e.l);
            end
        end
    endtask

    task automatic test_random();
        logic acc, ovld;
        logic [VB*PC-1:0] ov;
        logic [VB-1:0] val;
        logic lst, v, r;
        word_t g, e;
        int sent = 0;
        int cycles = 0;
        int nwords;
        val = 8'($urandom);
        lst = ($urandom_range(0, 9) == 0);
        while (sent < 2000 && cycles < 20000) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 6);
            drive_cycle(v, val, lst, r, acc, ovld, ov);
            if (acc) begin
                sent++;
                val = 8'($urandom);
                lst = ($urandom_range(0, 9) == 0);
            end
            cycles++;
        end
        n_cmp++;
        if (sent != 2000) begin
            n_bad++;
            $display("FAIL random_timeout: sent %0d beats want 2000", sent);
        end
        drain(3);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count: got %0d words want %0d", got_q.size(), exp_q.size());
        end
        nwords = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g.v !== e.v || g.c !== e.c || g.l !== e.l) begin
                n_bad++;
                $display("FAIL random_word[%0d]: got %08h/%0d/%b want %08h/%0d/%b",
                         nwords, g.v, g.c, g.l, e.v, e.c, e.l);
            end
            nwords++;
        end
        n_cmp++;
        if (mdl_fill != 0 && got_q.size() == 0) begin
            // A trailing partial word stays inside the block; close it out.
            send_beat(8'h5A, 1'b1);
            drain(2);
            if (got_q.size() != 1 || exp_q.size() != 1) begin
                n_bad++;
                $display("FAIL random_tail: got %0d words want 1", got_q.size());
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g.v !== e.v || g.c !== e.c || g.l !== e.l) begin
                    n_bad++;
                    $display("FAIL random_tail_word: got %08h/%0d/%b want %08h/%0d/%b",
                             g.v, g.c, g.l, e.v, e.c, e.l);
                end
            end
        end else if (got_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL random_leftover: got %0d extra, want %0d extra", got_q.size(), exp_q.size());
        end
    endtask

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0;
        i_value = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        mdl_clear();
        test_reset();
        test_full_word();
        test_single_last();
        test_stall();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
